// File: rtl/mult_arbiter_if.sv
// Bus bundle between the requesting datapaths, the arbiter and the shared multiplier.
interface mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       res_valid;
    logic [2*WIDTH-1:0]     result;
    logic                   err;
    logic                   mul_init;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_result;

    // Arbiter side.
    modport slave (
        input  req, op_a, op_b, mul_done, mul_result,
        output grant, res_valid, result, err, mul_init, mul_a, mul_b
    );

    // Requesters plus multiplier side.
    modport master (
        output req, op_a, op_b, mul_done, mul_result,
        input  grant, res_valid, result, err, mul_init, mul_a, mul_b
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among N_REQ requesters,
// with a watchdog that aborts a stalled multiply and raises a sticky error.
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    mult_arbiter_if.slave  bus
);
    localparam int          PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR = N_REQ;
    localparam int          CW = 10;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t               state_q;
    logic [PW-1:0]        ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [N_REQ-1:0]     grant_q;
    logic [N_REQ-1:0]     res_valid_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 err_q;
    logic                 mul_init_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;

    logic                 win_vld_d;
    logic [PW-1:0]        win_idx_d;
    logic [PW-1:0]        cand;
    logic [N_REQ-1:0]     win_oh_d;
    logic [WIDTH-1:0]     op_a_d;
    logic [WIDTH-1:0]     op_b_d;

    // Round-robin search starting one past the last winner; first set request wins.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = PW'((32'(ptr_q) + k) % NR);
            if (!win_vld_d && bus.req[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
        win_oh_d            = '0;
        win_oh_d[win_idx_d] = 1'b1;
        op_a_d              = bus.op_a[win_idx_d*WIDTH +: WIDTH];
        op_b_d              = bus.op_b[win_idx_d*WIDTH +: WIDTH];
    end

    // Sequencer: grant, wait for done or watchdog, then drain until done falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(N_REQ - 1);
            cnt_q       <= '0;
            grant_q     <= '0;
            res_valid_q <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            mul_init_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            res_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d && !bus.mul_done) begin
                        grant_q    <= win_oh_d;
                        mul_a_q    <= op_a_d;
                        mul_b_q    <= op_b_d;
                        mul_init_q <= 1'b1;
                        ptr_q      <= win_idx_d;
                        cnt_q      <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mul_done) begin
                        result_q    <= bus.mul_result;
                        res_valid_q <= grant_q;
                        grant_q     <= '0;
                        mul_init_q  <= 1'b0;
                        state_q     <= DRAIN;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        err_q      <= 1'b1;
                        grant_q    <= '0;
                        mul_init_q <= 1'b0;
                        state_q    <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!bus.mul_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.mul_init  = mul_init_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: table vectors, corner-case sequences
// and randomized transactions against a round-robin reference model.
module tb_mult_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]   req_v = '0;
    logic [N*W-1:0] opa   = '0;
    logic [N*W-1:0] opb   = '0;
    assign bus.req  = req_v;
    assign bus.op_a = opa;
    assign bus.op_b = opb;

    // Multiplier model: done 12 cycles after init seen, held 21 cycles.
    logic        mdl_done = 1'b0;
    logic [31:0] prod     = '0;
    int          mcnt     = 0;
    int          mhold    = 0;
    bit          stall    = 1'b0;
    assign bus.mul_done   = mdl_done;
    assign bus.mul_result = prod;

    // Multiplier behaviour.
    always @(posedge clk) begin
        if (mdl_done) begin
            if (mhold == 20) begin
                mdl_done <= 1'b0;
                mhold    <= 0;
            end else begin
                mhold <= mhold + 1;
            end
        end else if (bus.mul_init && !stall) begin
            if (mcnt == 11) begin
                mdl_done <= 1'b1;
                prod     <= 32'(bus.mul_a) * 32'(bus.mul_b);
                mcnt     <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Round-robin reference: first set bit after the last winner.
    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Protocol invariants sampled every cycle.
    logic [N-1:0] prev_grant = '0;
    logic         prev_done  = 1'b0;
    bit           mon_en     = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("grant_and_valid_overlap", 64'(bus.grant & bus.res_valid), 64'd0);
            chk("grant_onehot", 64'($countones(bus.grant) <= 1), 64'd1);
            if (rst) chk("valid_during_rst", 64'(bus.res_valid), 64'd0);
            if (prev_grant == '0 && bus.grant != '0)
                chk("grant_while_done", 64'(prev_done), 64'd0);
        end
        prev_grant = bus.grant;
        prev_done  = bus.mul_done;
    end

    // One served transaction: grant, operands, result pulse.
    task automatic txn(input int idx, input logic [31:0] exp_res,
                       input bit perturb, input logic [W-1:0] new_a);
        int n;
        n = 0;
        while (bus.grant == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.grant == '0) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: got no grant expected index %0d", idx);
            return;
        end
        chk("grant", 64'(bus.grant), 64'(1 << idx));
        chk("mul_a", 64'(bus.mul_a), 64'(opa[idx*W +: W]));
        chk("mul_b", 64'(bus.mul_b), 64'(opb[idx*W +: W]));
        chk("mul_init", 64'(bus.mul_init), 64'd1);
        if (perturb) begin
            opa[idx*W +: W] = new_a;
            req_v[idx]      = 1'b0;
        end
        n = 0;
        while (bus.res_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.res_valid == '0) begin
            checks++;
            errors++;
            $display("FAIL result_wait: got no res_valid expected index %0d", idx);
            return;
        end
        chk("res_valid", 64'(bus.res_valid), 64'(1 << idx));
        chk("result", 64'(bus.result), 64'(exp_res));
        chk("grant_cleared", 64'(bus.grant), 64'd0);
        req_v[idx] = 1'b0;
        @(negedge clk);
        chk("res_valid_one_cycle", 64'(bus.res_valid), 64'd0);
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        int             idx;
        logic [31:0]    res;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int ref_ptr;
        int n;
        int w;
        logic [31:0] res_before;
        logic [W-1:0] ra;

        tbl[0] = '{4'b1111, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 0, 32'd14};
        tbl[1] = '{4'b1111, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 1, 32'd21};
        tbl[2] = '{4'b1111, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 2, 32'd28};
        tbl[3] = '{4'b1111, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 3, 32'd35};
        tbl[4] = '{4'b1111, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 0, 32'd14};
        tbl[5] = '{4'b0010, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 1, 32'd21};
        tbl[6] = '{4'b1010, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 3, 32'd35};
        tbl[7] = '{4'b1010, 64'h0005_0004_0003_0002, 64'h0007_0007_0007_0007, 1, 32'd21};
        tbl[8] = '{4'b0001, 64'h0005_0004_0003_0003, 64'h0007_0007_0007_0005, 0, 32'd15};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_mul_init", 64'(bus.mul_init), 64'd0);
        chk("rst_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        rst     = 1'b0;
        ref_ptr = N - 1;

        // Table vectors: fairness, pointer behaviour, single request.
        for (int i = 0; i < 9; i++) begin
            req_v = tbl[i].req;
            opa   = tbl[i].a;
            opb   = tbl[i].b;
            txn(tbl[i].idx, tbl[i].res, 1'b0, '0);
            ref_ptr = tbl[i].idx;
        end

        // Operands change and req drops mid-service: latched values still used.
        req_v = 4'b0001;
        opa[0 +: W] = 16'd3;
        opb[0 +: W] = 16'd5;
        txn(rr_pick(ref_ptr, req_v), 32'd15, 1'b1, 16'd9);
        ref_ptr = 0;

        // Watchdog: multiplier never answers.
        stall       = 1'b1;
        res_before  = bus.result;
        req_v       = 4'b0100;
        opa[2*W +: W] = 16'd6;
        opb[2*W +: W] = 16'd7;
        w = rr_pick(ref_ptr, req_v);
        n = 0;
        while (bus.grant == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_grant", 64'(bus.grant), 64'(1 << w));
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            chk("to_err_early", 64'(bus.err), 64'd0);
            chk("to_grant_held", 64'(bus.grant), 64'(1 << w));
        end
        @(negedge clk);
        chk("to_err", 64'(bus.err), 64'd1);
        chk("to_grant_clr", 64'(bus.grant), 64'd0);
        chk("to_init_clr", 64'(bus.mul_init), 64'd0);
        chk("to_no_valid", 64'(bus.res_valid), 64'd0);
        chk("to_result_kept", 64'(bus.result), 64'(res_before));
        ref_ptr = w;
        req_v   = 4'b0001;
        stall   = 1'b0;
        opa[0 +: W] = 16'd4;
        opb[0 +: W] = 16'd4;
        txn(rr_pick(ref_ptr, req_v), 32'd16, 1'b0, '0);
        chk("err_sticky", 64'(bus.err), 64'd1);
        ref_ptr = 0;

        // Reset while done is high and the arbiter still waits.
        req_v = 4'b0001;
        opa[0 +: W] = 16'd5;
        opb[0 +: W] = 16'd6;
        n = 0;
        while (bus.mul_done == 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_done_seen", 64'(bus.mul_done), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_grant", 64'(bus.grant), 64'd0);
        chk("rm_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rm_result", 64'(bus.result), 64'd0);
        chk("rm_err", 64'(bus.err), 64'd0);
        chk("rm_init", 64'(bus.mul_init), 64'd0);
        chk("rm_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        ref_ptr = N - 1;
        n = 0;
        while (bus.mul_done && n < 50) begin
            chk("rm_no_grant_while_done", 64'(bus.grant), 64'd0);
            @(negedge clk);
            n++;
        end
        txn(rr_pick(ref_ptr, req_v), 32'd30, 1'b0, '0);
        ref_ptr = 0;

        // Randomized transactions against the reference model.
        for (int it = 0; it < 30; it++) begin
            req_v = 4'($urandom_range(1, 15));
            for (int r = 0; r < N; r++) begin
                opa[r*W +: W] = 16'($urandom);
                opb[r*W +: W] = 16'($urandom);
            end
            w  = rr_pick(ref_ptr, req_v);
            ra = 16'($urandom);
            txn(w, 32'(opa[w*W +: W]) * 32'(opb[w*W +: W]), 1'($urandom_range(0, 1)), ra);
            ref_ptr = w;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end
endmodule
